// File: rtl/dimm_sdram_ctrl_if.sv
// Host-side request/response bus of the SDRAM command sequencer.
// The host drives the master side; the controller drives the slave side.
interface dimm_sdram_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [20:0] req_addr;
    logic [63:0] req_wdata;
    logic [7:0]  req_wmask;
    logic        rd_valid;
    logic [63:0] rd_data;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_wmask,
        input  req_ready, rd_valid, rd_data
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_wmask,
        output req_ready, rd_valid, rd_data
    );
endinterface

// File: rtl/dimm_sdram_ctrl.sv
// SDRAM command sequencer for the 64-bit dimm: power-up init, periodic
// auto-refresh and single-word ACTIVE / READ|WRITE / PRECHARGE accesses.
module dimm_sdram_ctrl #(
    parameter int         INIT_CYCLES  = 100,
    parameter int         T_RCD        = 2,
    parameter int         T_RP         = 2,
    parameter int         T_RC         = 6,
    parameter int         T_WR         = 2,
    parameter int         CAS_LAT      = 2,
    parameter int         REF_INTERVAL = 780,
    parameter logic [10:0] MODE_REG    = 11'h020
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    dimm_sdram_ctrl_if.slave     host,
    output logic                 init_done_o,
    output logic                 csx_o,
    output logic                 rasx_o,
    output logic                 casx_o,
    output logic                 wex_o,
    output logic                 cke_o,
    output logic                 ba_o,
    output logic [10:0]          addr_o,
    output logic [7:0]           dqm_o,
    output logic [63:0]          dq_out_o,
    output logic                 dq_oe_o,
    input  logic [63:0]          dq_in_i
);
    localparam logic [3:0] CMD_NOP   = 4'b0111;
    localparam logic [3:0] CMD_ACT   = 4'b0011;
    localparam logic [3:0] CMD_READ  = 4'b0101;
    localparam logic [3:0] CMD_WRITE = 4'b0100;
    localparam logic [3:0] CMD_PRE   = 4'b0010;
    localparam logic [3:0] CMD_REF   = 4'b0001;
    localparam logic [3:0] CMD_MRS   = 4'b0000;
    localparam logic [3:0] CMD_DESEL = 4'b1111;

    localparam int CNT_W = 16;
    localparam int REF_W = $clog2(REF_INTERVAL);

    // The next ACTIVE lands one cycle after req_ready returns, so the
    // precharge wait is stretched whenever that would violate T_RC.
    localparam int RD_GAP = T_RCD + CAS_LAT;
    localparam int WR_GAP = T_RCD + T_WR;
    localparam int PRE_RD = (T_RC - 1 - RD_GAP > T_RP) ? T_RC - 1 - RD_GAP : T_RP;
    localparam int PRE_WR = (T_RC - 1 - WR_GAP > T_RP) ? T_RC - 1 - WR_GAP : T_RP;

    typedef enum logic [3:0] {
        S_INIT_WAIT, S_INIT_PRE, S_INIT_REF1, S_INIT_REF2, S_INIT_MRS,
        S_IDLE, S_REFRESH, S_ACTIVATE, S_RW, S_CAS_WAIT, S_PRECHARGE
    } state_e;

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [REF_W-1:0]   ref_cnt_q;
    logic               ref_pend_q;
    logic [3:0]         cmd_q;
    logic               cke_q, ba_q, dq_oe_q, ready_q, rd_valid_q, init_done_q;
    logic [10:0]        addr_q;
    logic [7:0]         dqm_q, wmask_q;
    logic [63:0]        dq_out_q, rd_data_q, wdata_q;
    logic               we_q;
    logic [8:0]         col_q;
    logic [CAS_LAT:0]   rd_pipe_q;

    logic wait_done, ref_set;
    assign wait_done = (cnt_q == '0);
    assign ref_set   = init_done_q && (ref_cnt_q == '0);

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q     <= S_INIT_WAIT;
            cnt_q       <= CNT_W'(INIT_CYCLES);
            ref_cnt_q   <= REF_W'(REF_INTERVAL - 1);
            ref_pend_q  <= 1'b0;
            cmd_q       <= CMD_DESEL;
            cke_q       <= 1'b0;
            ba_q        <= 1'b0;
            addr_q      <= '0;
            dqm_q       <= '1;
            dq_oe_q     <= 1'b0;
            dq_out_q    <= '0;
            ready_q     <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
            init_done_q <= 1'b0;
            rd_pipe_q   <= '0;
            we_q        <= 1'b0;
            col_q       <= '0;
            wdata_q     <= '0;
            wmask_q     <= '0;
        end else begin
            cke_q      <= 1'b1;
            cmd_q      <= CMD_NOP;
            dq_oe_q    <= 1'b0;
            dqm_q      <= (|rd_pipe_q[CAS_LAT-1:0]) ? 8'h00 : 8'hFF;
            // rd_pipe_q[k] marks the k-th cycle after READ; data is taken at CAS_LAT
            rd_pipe_q  <= {rd_pipe_q[CAS_LAT-1:0], 1'b0};
            rd_valid_q <= rd_pipe_q[CAS_LAT];
            if (rd_pipe_q[CAS_LAT]) rd_data_q <= dq_in_i;
            if (!wait_done) cnt_q <= cnt_q - 1'b1;

            if (init_done_q) ref_cnt_q <= ref_set ? REF_W'(REF_INTERVAL - 1) : ref_cnt_q - 1'b1;
            ref_pend_q <= ref_pend_q | ref_set;

            case (state_q)
                S_INIT_WAIT: if (wait_done) begin
                    cmd_q   <= CMD_PRE;
                    addr_q  <= 11'h400;
                    cnt_q   <= CNT_W'(T_RP - 1);
                    state_q <= S_INIT_PRE;
                end
                S_INIT_PRE: if (wait_done) begin
                    cmd_q   <= CMD_REF;
                    cnt_q   <= CNT_W'(T_RC - 1);
                    state_q <= S_INIT_REF1;
                end
                S_INIT_REF1: if (wait_done) begin
                    cmd_q   <= CMD_REF;
                    cnt_q   <= CNT_W'(T_RC - 1);
                    state_q <= S_INIT_REF2;
                end
                S_INIT_REF2: if (wait_done) begin
                    cmd_q   <= CMD_MRS;
                    addr_q  <= MODE_REG;
                    ba_q    <= 1'b0;
                    cnt_q   <= CNT_W'(1);
                    state_q <= S_INIT_MRS;
                end
                S_INIT_MRS: if (wait_done) begin
                    init_done_q <= 1'b1;
                    ready_q     <= 1'b1;
                    state_q     <= S_IDLE;
                end
                S_IDLE: begin
                    if (ref_pend_q) begin
                        cmd_q   <= CMD_REF;
                        cnt_q   <= CNT_W'(T_RC - 1);
                        ready_q <= 1'b0;
                        state_q <= S_REFRESH;
                    end else if (host.req_valid && ready_q) begin
                        we_q    <= host.req_we;
                        col_q   <= host.req_addr[8:0];
                        wdata_q <= host.req_wdata;
                        wmask_q <= host.req_wmask;
                        cmd_q   <= CMD_ACT;
                        ba_q    <= host.req_addr[20];
                        addr_q  <= host.req_addr[19:9];
                        cnt_q   <= CNT_W'(T_RCD - 1);
                        ready_q <= 1'b0;
                        state_q <= S_ACTIVATE;
                    end else begin
                        ready_q <= !ref_set;
                    end
                end
                S_REFRESH: if (wait_done) begin
                    ref_pend_q <= ref_set;
                    ready_q    <= !ref_set;
                    state_q    <= S_IDLE;
                end
                S_ACTIVATE: if (wait_done) begin
                    addr_q <= {2'b00, col_q};
                    if (we_q) begin
                        cmd_q    <= CMD_WRITE;
                        dq_out_q <= wdata_q;
                        dq_oe_q  <= 1'b1;
                        dqm_q    <= ~wmask_q;
                        cnt_q    <= CNT_W'(T_WR - 1);
                        state_q  <= S_RW;
                    end else begin
                        cmd_q        <= CMD_READ;
                        dqm_q        <= 8'h00;
                        rd_pipe_q[0] <= 1'b1;
                        cnt_q        <= CNT_W'(CAS_LAT - 1);
                        state_q      <= S_CAS_WAIT;
                    end
                end
                S_RW: if (wait_done) begin
                    cmd_q   <= CMD_PRE;
                    addr_q  <= '0;
                    cnt_q   <= CNT_W'(PRE_WR - 1);
                    state_q <= S_PRECHARGE;
                end
                S_CAS_WAIT: if (wait_done) begin
                    cmd_q   <= CMD_PRE;
                    addr_q  <= '0;
                    cnt_q   <= CNT_W'(PRE_RD - 1);
                    state_q <= S_PRECHARGE;
                end
                S_PRECHARGE: if (wait_done) begin
                    ready_q <= !(ref_pend_q | ref_set);
                    state_q <= S_IDLE;
                end
                default: state_q <= S_INIT_WAIT;
            endcase
        end
    end

    assign {csx_o, rasx_o, casx_o, wex_o} = cmd_q;
    assign cke_o          = cke_q;
    assign ba_o           = ba_q;
    assign addr_o         = addr_q;
    assign dqm_o          = dqm_q;
    assign dq_out_o       = dq_out_q;
    assign dq_oe_o        = dq_oe_q;
    assign init_done_o    = init_done_q;
    assign host.req_ready = ready_q;
    assign host.rd_valid  = rd_valid_q;
    assign host.rd_data   = rd_data_q;
endmodule

// File: tb/tb_dimm_sdram_ctrl.sv
// Directed bench for dimm_sdram_ctrl with a small behavioural SDRAM model
// that stores masked writes and returns read data CAS_LAT cycles after READ.
module tb_dimm_sdram_ctrl;
    localparam logic [3:0] C_NOP = 4'b0111, C_ACT = 4'b0011, C_RD  = 4'b0101, C_WR = 4'b0100;
    localparam logic [3:0] C_PRE = 4'b0010, C_REF = 4'b0001, C_MRS = 4'b0000, C_DES = 4'b1111;
    localparam logic [63:0] JUNK = 64'hA5A5_A5A5_A5A5_A5A5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dimm_sdram_ctrl_if bus();
    logic        init_done, csx, rasx, casx, wex, cke, ba, dq_oe;
    logic [10:0] addr;
    logic [7:0]  dqm;
    logic [63:0] dq_out;
    logic [63:0] dq_in = JUNK;
    logic [3:0]  cmd;
    assign cmd = {csx, rasx, casx, wex};

    dimm_sdram_ctrl dut (
        .clk_i(clk), .rst_n_i(rst_n), .host(bus), .init_done_o(init_done),
        .csx_o(csx), .rasx_o(rasx), .casx_o(casx), .wex_o(wex), .cke_o(cke),
        .ba_o(ba), .addr_o(addr), .dqm_o(dqm), .dq_out_o(dq_out), .dq_oe_o(dq_oe),
        .dq_in_i(dq_in)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0, fails = 0, init_cyc = 0;

    logic [63:0] mem [logic [20:0]];
    logic [10:0] open_row [2];
    int          rd_cd = 0;
    logic [63:0] rd_buf = '0;

    always @(negedge clk) begin
        logic [20:0] key;
        logic [63:0] w;
        key = {ba, open_row[ba], addr[8:0]};
        if (rd_cd > 0) begin
            rd_cd--;
            dq_in = (rd_cd == 0) ? rd_buf : JUNK;
        end else dq_in = JUNK;
        if (rst_n) begin
            case (cmd)
                C_ACT: open_row[ba] = addr;
                C_WR: begin
                    w = mem.exists(key) ? mem[key] : 64'h0;
                    for (int b = 0; b < 8; b++) if (!dqm[b]) w[b*8 +: 8] = dq_out[b*8 +: 8];
                    mem[key] = w;
                end
                C_RD: begin
                    rd_buf = mem.exists(key) ? mem[key] : 64'h0;
                    rd_cd  = 2;
                end
                default: ;
            endcase
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    // Presents one request and returns the accept cycle T; caller resumes at T+1
    // with the request fields scrambled so that latching is exercised.
    task automatic send(input logic we, input logic [20:0] a, input logic [63:0] d,
                        input logic [7:0] m, output int t);
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_addr = a;
        bus.req_wdata = d;    bus.req_wmask = m;
        t = -1;
        for (int i = 0; i < 60; i++) begin
            if (bus.req_ready) begin t = cyc; break; end
            @(negedge clk);
        end
        if (t < 0) begin
            tests++; fails++;
            $display("FAIL send_timeout: req_ready never seen, required within 60 cycles");
        end
        @(negedge clk);
        bus.req_valid = 1'b0; bus.req_we = ~we; bus.req_addr = ~a;
        bus.req_wdata = ~d;   bus.req_wmask = ~m;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if (cmd !== C_DES || cke !== 1'b0 || addr !== 11'h0 || ba !== 1'b0) begin
            fails++;
            $display("FAIL reset_pins: cmd=%b cke=%b addr=%h ba=%b, required 1111 0 000 0", cmd, cke, addr, ba);
        end
        tests++;
        if (dqm !== 8'hFF || dq_oe !== 1'b0 || dq_out !== 64'h0) begin
            fails++;
            $display("FAIL reset_data: dqm=%h dq_oe=%b dq_out=%h, required ff 0 0", dqm, dq_oe, dq_out);
        end
        tests++;
        if (bus.req_ready !== 1'b0 || bus.rd_valid !== 1'b0 || bus.rd_data !== 64'h0 || init_done !== 1'b0) begin
            fails++;
            $display("FAIL reset_host: ready=%b rd_valid=%b rd_data=%h init_done=%b, required all 0",
                     bus.req_ready, bus.rd_valid, bus.rd_data, init_done);
        end
    endtask

    // Caller releases reset on a falling edge; cycle 1 follows the next rising edge.
    task automatic test_init(input string tag);
        int bad_cmd = 0, bad_cke = 0, bad_done = 0;
        logic [3:0] e;
        logic ready_end = 1'b0;
        for (int c = 1; c <= 117; c++) begin
            @(negedge clk);
            e = C_NOP;
            if (c == 101) e = C_PRE;
            if (c == 103 || c == 109) e = C_REF;
            if (c == 115) e = C_MRS;
            if (cmd !== e) bad_cmd++;
            if (c == 101 && addr[10] !== 1'b1) bad_cmd++;
            if (c == 115 && (addr !== 11'h020 || ba !== 1'b0)) bad_cmd++;
            if (cke !== 1'b1) bad_cke++;
            if (init_done !== (c == 117)) bad_done++;
            if (c == 117) begin init_cyc = cyc; ready_end = bus.req_ready; end
        end
        tests++;
        if (bad_cmd != 0) begin fails++; $display("FAIL %s_cmd_seq: %0d bad cycles, required 0", tag, bad_cmd); end
        tests++;
        if (bad_cke != 0) begin fails++; $display("FAIL %s_cke: %0d cycles with cke low, required 0", tag, bad_cke); end
        tests++;
        if (bad_done != 0) begin fails++; $display("FAIL %s_init_done: %0d bad cycles, required 0", tag, bad_done); end
        tests++;
        if (ready_end !== 1'b1) begin fails++; $display("FAIL %s_ready: req_ready=%b after init, required 1", tag, ready_end); end
    endtask

    task automatic test_write();
        int t;
        send(1'b1, {1'b1, 11'h155, 9'h0AA}, 64'hDEADBEEF_01234567, 8'h0F, t);
        tests++;
        if (cmd !== C_ACT || ba !== 1'b1 || addr !== 11'h155) begin
            fails++; $display("FAIL wr_active: cmd=%b ba=%b addr=%h, required 0011 1 155", cmd, ba, addr);
        end
        repeat (2) @(negedge clk);
        tests++;
        if (cmd !== C_WR || addr !== 11'h0AA || dqm !== 8'hF0 || dq_oe !== 1'b1 || dq_out !== 64'hDEADBEEF_01234567) begin
            fails++;
            $display("FAIL wr_write: cmd=%b addr=%h dqm=%h oe=%b dq=%h, required 0100 0aa f0 1 deadbeef01234567",
                     cmd, addr, dqm, dq_oe, dq_out);
        end
        @(negedge clk);
        tests++;
        if (cmd !== C_NOP || dqm !== 8'hFF || dq_oe !== 1'b0) begin
            fails++; $display("FAIL wr_after: cmd=%b dqm=%h oe=%b, required 0111 ff 0", cmd, dqm, dq_oe);
        end
        @(negedge clk);
        tests++;
        if (cmd !== C_PRE || addr[10] !== 1'b0 || ba !== 1'b1) begin
            fails++; $display("FAIL wr_precharge: cmd=%b a10=%b ba=%b, required 0010 0 1", cmd, addr[10], ba);
        end
        @(negedge clk);
        tests++;
        if (bus.req_ready !== 1'b0) begin fails++; $display("FAIL wr_ready_t6: req_ready=%b, required 0", bus.req_ready); end
        @(negedge clk);
        tests++;
        if (bus.req_ready !== 1'b1) begin fails++; $display("FAIL wr_ready_t7: req_ready=%b, required 1", bus.req_ready); end
    endtask

    task automatic test_read();
        int t;
        send(1'b0, {1'b1, 11'h155, 9'h0AA}, 64'h0, 8'h00, t);
        tests++;
        if (cmd !== C_ACT || ba !== 1'b1 || addr !== 11'h155) begin
            fails++; $display("FAIL rd_active: cmd=%b ba=%b addr=%h, required 0011 1 155", cmd, ba, addr);
        end
        repeat (2) @(negedge clk);
        tests++;
        if (cmd !== C_RD || addr !== 11'h0AA || dqm !== 8'h00) begin
            fails++; $display("FAIL rd_read: cmd=%b addr=%h dqm=%h, required 0101 0aa 00", cmd, addr, dqm);
        end
        repeat (2) @(negedge clk);
        tests++;
        if (cmd !== C_PRE || bus.rd_valid !== 1'b0) begin
            fails++; $display("FAIL rd_t5: cmd=%b rd_valid=%b, required 0010 0", cmd, bus.rd_valid);
        end
        @(negedge clk);
        tests++;
        if (bus.rd_valid !== 1'b1 || bus.rd_data !== 64'h00000000_01234567) begin
            fails++; $display("FAIL rd_data: rd_valid=%b rd_data=%h, required 1 0000000001234567", bus.rd_valid, bus.rd_data);
        end
        @(negedge clk);
        tests++;
        if (bus.rd_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
            fails++; $display("FAIL rd_t7: rd_valid=%b ready=%b, required 0 1", bus.rd_valid, bus.req_ready);
        end
    endtask

    task automatic test_refresh_collision();
        int p;
        int lowbad = 0;
        p = init_cyc + 780;
        while (cyc < p - 1) @(negedge clk);
        tests++;
        if (bus.req_ready !== 1'b1) begin fails++; $display("FAIL col_pre_ready: req_ready=%b, required 1", bus.req_ready); end
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = {1'b0, 11'h2AA, 9'h155};
        bus.req_wdata = 64'h1111_2222_3333_4444; bus.req_wmask = 8'hFF;
        tests++;
        if (bus.req_ready !== 1'b0) begin fails++; $display("FAIL col_expiry_ready: req_ready=%b, required 0", bus.req_ready); end
        for (int j = 1; j <= 6; j++) begin
            @(negedge clk);
            if (j == 1 && cmd !== C_REF) lowbad++;
            if (bus.req_ready !== 1'b0 || cmd == C_ACT) lowbad++;
        end
        tests++;
        if (lowbad != 0) begin fails++; $display("FAIL col_refresh: %0d bad cycles in refresh window, required 0", lowbad); end
        @(negedge clk);
        tests++;
        if (bus.req_ready !== 1'b1) begin fails++; $display("FAIL col_ready_back: req_ready=%b, required 1", bus.req_ready); end
        @(negedge clk);
        bus.req_valid = 1'b0;
        tests++;
        if (cmd !== C_ACT || addr !== 11'h2AA || ba !== 1'b0) begin
            fails++; $display("FAIL col_active: cmd=%b addr=%h ba=%b, required 0011 2aa 0", cmd, addr, ba);
        end
        repeat (8) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int last_act = -100, last_pre = -100, min_gap = 1000;
        int nact = 0, refs = 0, bad_ref = 0, pend;
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = {1'b1, 11'h033, 9'h011};
        bus.req_wdata = 64'h0F0F_0F0F_0F0F_0F0F; bus.req_wmask = 8'hFF;
        while (cyc < init_cyc + 2340 + 40) begin
            @(negedge clk);
            if (cmd == C_ACT) begin
                if (last_act >= 0 && cyc - last_act < min_gap) min_gap = cyc - last_act;
                last_act = cyc; nact++;
            end
            if (cmd == C_PRE) last_pre = cyc;
            if (cmd == C_REF) begin
                refs++;
                pend = init_cyc + 780 * ((cyc - init_cyc) / 780);
                if (cyc - pend < 1 || cyc - pend > 7) bad_ref++;
                if (last_act > pend) bad_ref++;
                if (last_pre < last_act || cyc - last_pre < 2) bad_ref++;
            end
        end
        bus.req_valid = 1'b0;
        tests++;
        if (min_gap != 7) begin fails++; $display("FAIL b2b_act_gap: min ACTIVE spacing %0d, required 7", min_gap); end
        tests++;
        if (nact < 200) begin fails++; $display("FAIL b2b_act_count: %0d ACTIVEs, required at least 200", nact); end
        tests++;
        if (refs != 2) begin fails++; $display("FAIL b2b_ref_count: %0d REFRESHes, required 2", refs); end
        tests++;
        if (bad_ref != 0) begin fails++; $display("FAIL b2b_ref_place: %0d misplaced REFRESH checks, required 0", bad_ref); end
        repeat (10) @(negedge clk);
    endtask

    task automatic test_reset_mid_read();
        int t;
        int bad = 0;
        send(1'b0, {1'b1, 11'h155, 9'h0AA}, 64'h0, 8'h00, t);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        tests++;
        if (cmd !== C_DES || cke !== 1'b0 || addr !== 11'h0 || ba !== 1'b0 || dqm !== 8'hFF ||
            dq_oe !== 1'b0 || dq_out !== 64'h0) begin
            fails++;
            $display("FAIL mid_reset_pins: cmd=%b cke=%b addr=%h ba=%b dqm=%h oe=%b dq=%h, required reset values",
                     cmd, cke, addr, ba, dqm, dq_oe, dq_out);
        end
        tests++;
        if (bus.req_ready !== 1'b0 || bus.rd_data !== 64'h0 || init_done !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset_host: ready=%b rd_data=%h init_done=%b, required 0 0 0",
                     bus.req_ready, bus.rd_data, init_done);
        end
        for (int j = 0; j < 4; j++) begin
            if (bus.rd_valid !== 1'b0) bad++;
            @(negedge clk);
        end
        tests++;
        if (bad != 0) begin fails++; $display("FAIL mid_reset_rd_valid: %0d pulses, required 0", bad); end
        rst_n = 1'b1;
        test_init("reinit");
    endtask

    initial begin
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0;
        bus.req_wdata = '0;   bus.req_wmask = '0;
        test_reset();
        rst_n = 1'b1;
        test_init("init");
        @(negedge clk);
        test_write();
        test_read();
        test_refresh_collision();
        test_back_to_back();
        test_reset_mid_read();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/dimm_sdram_ctrl.md
# dimm_sdram_ctrl

Single-port SDRAM command sequencer that drives the 64-bit `dimm` memory module. It performs power-up initialisation, issues periodic auto-refresh, and converts one-word read/write requests from a host into ACTIVE / READ|WRITE / PRECHARGE command sequences. It sits between the system bus adapter and the `dimm` pins. Tristating of the data bus belongs to the top level, using `dq_oe`.

## Interface
- `INIT_CYCLES`, 100: NOP cycles after reset before the first PRECHARGE ALL.
- `T_RCD`, 2: cycles from ACTIVE to READ/WRITE.
- `T_RP`, 2: cycles from PRECHARGE to the next ACTIVE/REFRESH/MODE command.
- `T_RC`, 6: minimum cycles ACTIVE→ACTIVE and REFRESH→any command.
- `T_WR`, 2: cycles from WRITE to PRECHARGE.
- `CAS_LAT`, 2: cycles from READ to data valid on `dq_in`; legal values are 2 and 3.
- `REF_INTERVAL`, 780: cycles between refresh requests.
- `MODE_REG`, 11'h020: value driven on `addr` during LOAD MODE (CL2, burst length 1).
- `clk` input 1: clock, rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `req_valid` input 1: host request valid.
- `req_ready` output 1: controller accepts a request this cycle.
- `req_we` input 1: 1 = write, 0 = read.
- `req_addr` input 21: bank [20], row [19:9], column [8:0].
- `req_wdata` input 64: write data.
- `req_wmask` input 8: byte enables, 1 = write byte.
- `rd_valid` output 1: one-cycle pulse marking valid `rd_data`.
- `rd_data` output 64: read data.
- `init_done` output 1: high once initialisation is complete.
- `csx`, `rasx`, `casx`, `wex` output 1 each: active-low SDRAM command pins.
- `cke` output 1: clock enable.
- `ba` output 1: bank address.
- `addr` output 11: row/column/mode address.
- `dqm` output 8: byte masks, 1 = masked.
- `dq_out` output 64: write data toward the pins.
- `dq_oe` output 1: data output enable.
- `dq_in` input 64: data from the pins.

## Operation
- Command encoding on {csx,rasx,casx,wex}:
  - NOP = 0111, ACTIVE = 0011, READ = 0101, WRITE = 0100.
  - PRECHARGE = 0010, REFRESH = 0001, LOAD MODE = 0000.
  - DESELECT = 1111.
- All pin outputs are registered.
- Reset values:
  - Command = DESELECT; `cke` = 0; `addr` = 0; `ba` = 0.
  - `dqm` = 8'hFF; `dq_oe` = 0; `dq_out` = 0.
  - `req_ready` = 0; `rd_valid` = 0; `rd_data` = 0; `init_done` = 0.
- FSM states: INIT_WAIT → INIT_PRE → INIT_REF1 → INIT_REF2 → INIT_MRS → IDLE; the operating states are IDLE, REFRESH, ACTIVATE, RW, CAS_WAIT, PRECHARGE.
- One shared down-counter times every wait state.
- Initialisation sequence:
  - `cke` = 1 from the first cycle after reset is released.
  - INIT_CYCLES NOPs, then PRECHARGE ALL (`addr[10]` = 1) and T_RP of wait.
  - REFRESH followed by T_RC of wait, twice.
  - LOAD MODE with `addr` = MODE_REG, `ba` = 0, then 2 cycles of wait.
  - Enter IDLE and set `init_done` = 1; it stays high until reset.
- Refresh timer:
  - Starts when `init_done` rises and reloads REF_INTERVAL on every expiry.
  - Each expiry sets `ref_pending`.
- IDLE priority is `ref_pending` > request.
  - `req_ready` = 1 only in IDLE with `ref_pending` = 0.
  - Refresh sequence: REFRESH, then T_RC of wait, then `ref_pending` is cleared and the FSM returns to IDLE.
- Request path: ACTIVE with row on `addr` and bank on `ba`, then T_RCD of wait, then READ/WRITE.
  - READ/WRITE: column on `addr[8:0]`, `addr[10]` = 0.
  - WRITE: `dq_out` = `req_wdata`, `dq_oe` = 1 and `dqm` = ~`req_wmask` for exactly the WRITE cycle.
  - READ: `dqm` = 0 from READ until data capture.
- After the access, PRECHARGE (`addr[10]` = 0, same bank), then T_RP of wait, then IDLE.
- ACTIVE→ACTIVE spacing below T_RC is prevented by extending the PRECHARGE wait.
- Request fields are latched at acceptance; host changes afterwards have no effect.
- `dqm` = 8'hFF and `dq_oe` = 0 in every cycle not listed above.

## Timing
- Timing is stated relative to T, the cycle in which `req_valid & req_ready` is sampled high, with default parameters.
- ACTIVE appears on the pins at T+1.
- READ or WRITE appears at T+1+T_RCD = T+3.
- Read path:
  - `dq_in` is sampled at T+3+CAS_LAT = T+5.
  - `rd_valid` pulses at T+6 with the captured `rd_data`.
  - PRECHARGE is issued at T+5.
- Write path: PRECHARGE at T+3+T_WR = T+5.
- `req_ready` returns no earlier than PRECHARGE+T_RP = T+7; the next ACTIVE is therefore at T+8 or later, at least T_RC after the previous ACTIVE.
- Refresh that falls due mid-access is deferred until the access completes; no request is accepted before it.
- A request and `ref_pending` present together in IDLE: refresh first, `req_ready` held low, and the request is accepted once refresh completes.
- Deasserting `rst_n` mid-access: reset values apply at the next edge. The in-flight access is abandoned, no `rd_valid` is produced, and initialisation restarts.

## Test plan
- Reset release with `cke`/command monitor → 100 NOPs, PRECHARGE ALL, 2×REFRESH spaced 6 cycles apart, LOAD MODE with `addr` = 11'h020, then `init_done` = 1 exactly 2 cycles later.
- Write of 64'hDEADBEEF_01234567 with mask 8'h0F to bank 1, row 11'h155, column 9'h0AA → ACTIVE T+1 (`ba` = 1, `addr` = 11'h155), WRITE T+3 (`addr` = 11'h0AA, `dqm` = 8'hF0, `dq_oe` = 1), PRECHARGE T+5, `req_ready` high again at T+7.
- Read from the same address with the SDRAM model returning 64'h00000000_01234567 → READ at T+3, `rd_valid` single pulse at T+6 with `rd_data` = 64'h00000000_01234567.
- `req_valid` held high continuously → successive ACTIVE commands spaced at least 7 cycles apart; REFRESH issued every 780 cycles, never overlapping an access, and the request stalled while refresh is pending.
- Refresh expiry in the same cycle that `req_valid` rises in IDLE → REFRESH issued first, `req_ready` low for 6 cycles, then the request is accepted.
- `rst_n` driven low at T+4 of a read → all outputs at reset values on the next edge, no `rd_valid`, and the full initialisation sequence repeats after release.
